// File: rtl/wavegen_pkg.sv
// Shared widths, state encoding and phase type for the ECG waveform sequencer.
// The ROM itself is external; only its address and data widths are fixed here.
package wavegen_pkg;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 24;
  localparam int FRAC_W  = 6;
  localparam int DIV_W   = 16;
  localparam int PHASE_W = ADDR_W + FRAC_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } seq_state_t;

  typedef logic [PHASE_W-1:0] phase_t;

endpackage

// File: rtl/ecg_wave_sequencer_if.sv
// Valid/ready sample stream from the sequencer towards the DAC/FIR path.
// Signal names keep the sequencer-side port naming.
interface ecg_wave_sequencer_if #(
  parameter int DATA_W = wavegen_pkg::DATA_W
) ();

  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;

  modport master (output o_data, output o_valid, input i_ready);
  modport slave  (input o_data, input o_valid, output i_ready);

endinterface

// File: rtl/wave_rate_div.sv
// Sample-rate divider: counts 0..div while running and pulses tick on the last count.
// A clear or leaving RUN restarts the count from zero.
module wave_rate_div
  import wavegen_pkg::*;
#(
  parameter int DIV_W = wavegen_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !run) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ecg_wave_sequencer.sv
// Walks the external ECG ROM with a fractional phase accumulator and streams
// the samples out on a valid/ready interface, in loop or one-shot mode.
module ecg_wave_sequencer #(
  parameter int ADDR_W = wavegen_pkg::ADDR_W,
  parameter int DATA_W = wavegen_pkg::DATA_W,
  parameter int FRAC_W = wavegen_pkg::FRAC_W,
  parameter int DIV_W  = wavegen_pkg::DIV_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic                     i_oneshot,
  input  logic [ADDR_W+FRAC_W-1:0] i_step,
  input  logic [DIV_W-1:0]         i_div,
  output logic [ADDR_W-1:0]        o_lut_addr,
  input  logic [DATA_W-1:0]        i_lut_data,
  output logic                     o_busy,
  output logic                     o_beat,
  output logic                     o_overrun,
  ecg_wave_sequencer_if.master     stream
);

  import wavegen_pkg::*;

  localparam int PHASE_W = ADDR_W + FRAC_W;

  seq_state_t         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] step_q, step_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               oneshot_q, oneshot_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               beat_q, beat_d;
  logic               overrun_q, overrun_d;

  logic               tick;
  logic               stop_hit;
  logic               slot_free;
  logic               carry;
  logic [PHASE_W-1:0] phase_sum;

  assign {carry, phase_sum} = {1'b0, phase_q} + {1'b0, step_q};
  assign stop_hit  = i_stop && (state_q != IDLE);
  assign slot_free = !valid_q || stream.i_ready;

  wave_rate_div #(
    .DIV_W (DIV_W)
  ) u_rate_div (
    .clk   (i_clk),
    .rst   (i_rst),
    .clear (stop_hit || i_start),
    .run   (state_q == RUN),
    .div   (div_q),
    .tick  (tick)
  );

  // Stop beats start; a tick into a stalled output is dropped and flagged.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    step_d    = step_q;
    div_d     = div_q;
    oneshot_d = oneshot_q;
    data_d    = data_q;
    valid_d   = valid_q && !stream.i_ready;
    beat_d    = 1'b0;
    overrun_d = overrun_q;
    if (stop_hit) begin
      state_d = IDLE;
      phase_d = '0;
      valid_d = 1'b0;
    end else if (i_start) begin
      state_d   = RUN;
      phase_d   = '0;
      step_d    = i_step;
      div_d     = i_div;
      oneshot_d = i_oneshot;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (tick) begin
            if (slot_free) begin
              data_d  = i_lut_data;
              valid_d = 1'b1;
              phase_d = phase_sum;
              beat_d  = carry;
              if (carry && oneshot_q) begin
                state_d = FLUSH;
              end
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
        FLUSH: begin
          if (!valid_q || stream.i_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      step_q    <= '0;
      div_q     <= '0;
      oneshot_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      beat_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      step_q    <= step_d;
      div_q     <= div_d;
      oneshot_q <= oneshot_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      beat_q    <= beat_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_lut_addr     = phase_q[PHASE_W-1 -: ADDR_W];
  assign o_busy         = (state_q != IDLE);
  assign o_beat         = beat_q;
  assign o_overrun      = overrun_q;
  assign stream.o_data  = data_q;
  assign stream.o_valid = valid_q;

endmodule

// File: tb/tb_ecg_wave_sequencer.sv
// Self-checking bench for ecg_wave_sequencer: a behavioural ROM, a scoreboard of
// expected samples, table-driven stream configurations and hand-written corner cases.
module tb_ecg_wave_sequencer;
  import wavegen_pkg::*;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              beat;
  } exp_t;

  typedef struct {
    logic [PHASE_W-1:0] step;
    logic [DIV_W-1:0]   div;
    int                 n;
    int                 exp_gap;
    int                 exp_beats;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               start, stop, oneshot;
  logic [PHASE_W-1:0] step;
  logic [DIV_W-1:0]   div;
  logic [ADDR_W-1:0]  lut_addr;
  logic [DATA_W-1:0]  lut_data;
  logic               busy, beat, overrun;

  ecg_wave_sequencer_if stream_if ();

  ecg_wave_sequencer dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_stop     (stop),
    .i_oneshot  (oneshot),
    .i_step     (step),
    .i_div      (div),
    .o_lut_addr (lut_addr),
    .i_lut_data (lut_data),
    .o_busy     (busy),
    .o_beat     (beat),
    .o_overrun  (overrun),
    .stream     (stream_if)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_val(input logic [ADDR_W-1:0] a);
    return {a[3:0] ^ 4'h5, a, ~a};
  endfunction

  assign lut_data = rom_val(lut_addr);

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   beat_cnt = 0;
  logic sb_en = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_acc = 1'b0;
  logic fresh;
  logic cur_beat = 1'b0;
  exp_t exp_q[$];
  int   acc_cyc[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: compare every accepted beat against the next expected sample.
  always @(negedge clk) begin
    exp_t e;
    fresh = stream_if.o_valid && (!prev_valid || prev_acc);
    if (fresh) cur_beat = beat;
    if (beat) checkOutput("beat_with_new_sample", {31'd0, fresh}, 32'd1);
    if (sb_en && stream_if.o_valid && stream_if.i_ready) begin
      acc_cyc.push_back(cyc);
      if (cur_beat) beat_cnt++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_sample", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sample_data", {8'd0, stream_if.o_data}, {8'd0, e.data});
        checkOutput("sample_beat", {31'd0, cur_beat}, {31'd0, e.beat});
      end
    end
    prev_valid = stream_if.o_valid;
    prev_acc   = stream_if.o_valid && stream_if.i_ready;
  end

  task automatic applyStimulus(input logic [PHASE_W-1:0] s, input logic [DIV_W-1:0] d, input logic os);
    step    = s;
    div     = d;
    oneshot = os;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic pulseStop();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain_timeout: %0d samples still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pushModel(input logic [PHASE_W-1:0] s, input int n);
    phase_t            ph = '0;
    logic [PHASE_W:0]  sum;
    exp_t              e;
    for (int k = 0; k < n; k++) begin
      sum    = {1'b0, ph} + {1'b0, s};
      e.data = rom_val(ph[PHASE_W-1 -: ADDR_W]);
      e.beat = sum[PHASE_W];
      exp_q.push_back(e);
      ph     = sum[PHASE_W-1:0];
    end
  endtask

  vec_t vecs[4];

  initial begin
    exp_t e;
    int   n;

    vecs[0] = '{step: 16'd64,  div: 16'd0, n: 1040, exp_gap: 1, exp_beats: 1};
    vecs[1] = '{step: 16'd32,  div: 16'd3, n: 2050, exp_gap: 4, exp_beats: 1};
    vecs[2] = '{step: 16'd0,   div: 16'd1, n: 6,    exp_gap: 2, exp_beats: 0};
    vecs[3] = '{step: 16'd100, div: 16'd2, n: 700,  exp_gap: 3, exp_beats: 1};

    rst = 1'b1; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
    step = '0; div = '0; stream_if.i_ready = 1'b1;
    #12;
    checkOutput("reset_valid", {31'd0, stream_if.o_valid}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_data", {8'd0, stream_if.o_data}, 32'd0);
    checkOutput("reset_addr", {22'd0, lut_addr}, 32'd0);
    checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Looping stream configurations
    for (int r = 0; r < 4; r++) begin
      exp_q.delete();
      acc_cyc.delete();
      beat_cnt = 0;
      pushModel(vecs[r].step, vecs[r].n);
      sb_en = 1'b1;
      applyStimulus(vecs[r].step, vecs[r].div, 1'b0);
      checkOutput("run_busy", {31'd0, busy}, 32'd1);
      waitDrain(vecs[r].n * vecs[r].exp_gap + 20);
      #1;
      sb_en = 1'b0;
      for (int i = 1; i < acc_cyc.size() && i <= 8; i++)
        checkOutput("sample_gap", acc_cyc[i] - acc_cyc[i-1], vecs[r].exp_gap);
      checkOutput("beat_count", beat_cnt, vecs[r].exp_beats);
      pulseStop();
      repeat (2) @(posedge clk);
      #1;
    end

    // One-shot: 64 samples, final sample held in FLUSH until accepted
    exp_q.delete();
    for (int k = 0; k < 64; k++) begin
      e.data = rom_val(10'(k * 16));
      e.beat = (k == 63);
      exp_q.push_back(e);
    end
    sb_en = 1'b1;
    applyStimulus(16'd1024, 16'd0, 1'b1);
    n = 0;
    while (exp_q.size() > 1 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    stream_if.i_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("flush_busy", {31'd0, busy}, 32'd1);
      checkOutput("flush_valid", {31'd0, stream_if.o_valid}, 32'd1);
      checkOutput("flush_data", {8'd0, stream_if.o_data}, {8'd0, rom_val(10'd1008)});
    end
    stream_if.i_ready = 1'b1;
    waitDrain(10);
    #1;
    sb_en = 1'b0;
    checkOutput("oneshot_done_busy", {31'd0, busy}, 32'd0);
    checkOutput("oneshot_done_valid", {31'd0, stream_if.o_valid}, 32'd0);

    // Stall with div=0: output frozen, phase held, overrun sticky until restart
    applyStimulus(16'd64, 16'd0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    stream_if.i_ready = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      checkOutput("stall_data", {8'd0, stream_if.o_data}, {8'd0, rom_val(10'd4)});
      checkOutput("stall_addr", {22'd0, lut_addr}, 32'd5);
    end
    checkOutput("stall_overrun", {31'd0, overrun}, 32'd1);
    stream_if.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("overrun_sticky", {31'd0, overrun}, 32'd1);
    applyStimulus(16'd64, 16'd0, 1'b0);
    checkOutput("restart_overrun", {31'd0, overrun}, 32'd0);
    checkOutput("restart_valid", {31'd0, stream_if.o_valid}, 32'd0);
    pulseStop();

    // Simultaneous stop and start mid-run
    applyStimulus(16'd64, 16'd0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    checkOutput("stopstart_busy", {31'd0, busy}, 32'd0);
    checkOutput("stopstart_valid", {31'd0, stream_if.o_valid}, 32'd0);
    checkOutput("stopstart_addr", {22'd0, lut_addr}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stopstart_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset at sample 500, then restart from address 0
    exp_q.delete();
    pushModel(16'd64, 500);
    sb_en = 1'b1;
    applyStimulus(16'd64, 16'd0, 1'b0);
    waitDrain(600);
    #1;
    sb_en = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", {31'd0, stream_if.o_valid}, 32'd0);
    checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("async_rst_data", {8'd0, stream_if.o_data}, 32'd0);
    checkOutput("async_rst_addr", {22'd0, lut_addr}, 32'd0);
    checkOutput("async_rst_beat", {31'd0, beat}, 32'd0);
    checkOutput("async_rst_overrun", {31'd0, overrun}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    pushModel(16'd64, 5);
    sb_en = 1'b1;
    applyStimulus(16'd64, 16'd0, 1'b0);
    waitDrain(30);
    #1;
    sb_en = 1'b0;
    pulseStop();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ecg_wave_sequencer.md
Name: ecg_wave_sequencer

Overview:
- Sequences the 1024x24 ECG waveform lookup ROM (combinational read, 10-bit address, 24-bit data) into a rate-controlled sample stream.
- Generates ROM addresses from a fractional phase accumulator, paced by a programmable sample-rate divider.
- Registers ROM data onto a valid/ready output stream, with loop and one-shot (single beat) playback modes.
- Sits between the control register bank and the DAC/FIR stream path of the waveform generator.

Parameters:
- ADDR_W, 10, ROM address width; ROM depth is 2**ADDR_W.
- DATA_W, 24, ROM sample width.
- FRAC_W, 6, fractional phase bits below the address.
- DIV_W, 16, sample-rate divider width.

Ports:
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_start  in  1  single-cycle pulse: latch config, clear phase, enter RUN.
- i_stop  in  1  single-cycle pulse: abort and return to IDLE.
- i_oneshot  in  1  mode: 1 = one period then IDLE, 0 = loop.
- i_step  in  ADDR_W+FRAC_W  phase increment per sample.
- i_div  in  DIV_W  sample tick every i_div+1 clocks.
- o_lut_addr  out  ADDR_W  address to the ROM; equals phase[top ADDR_W bits].
- i_lut_data  in  DATA_W  ROM read data, combinational from o_lut_addr.
- o_data  out  DATA_W  registered sample.
- o_valid  out  1  o_data is valid.
- i_ready  in  1  downstream accepts o_data when o_valid & i_ready.
- o_busy  out  1  state != IDLE.
- o_beat  out  1  one-cycle pulse when the phase wraps.
- o_overrun  out  1  sticky: a tick was dropped because the output was stalled; cleared by i_start.

Behaviour:
- Reset values: phase = 0, state IDLE, divider counter = 0, o_data = 0, o_valid = 0, o_beat = 0, o_overrun = 0, o_busy = 0. Latched step/div/mode registers reset to 0.
- States:
  - IDLE: waits for i_start.
  - RUN: produces samples on each tick.
  - FLUSH: one-shot only; the final sample is waiting for acceptance.
- i_start in any state:
  - Latches i_step, i_div and i_oneshot.
  - Clears phase, divider counter and o_overrun.
  - Drops any pending sample (o_valid = 0).
  - Enters RUN next cycle.
- i_stop in any non-IDLE state: next cycle IDLE, o_valid = 0, phase = 0. Stop wins over a simultaneous start.
- Divider:
  - In RUN, the counter runs 0..div and a tick is asserted when counter == div, then the counter wraps to 0.
  - div = 0 gives a tick every cycle.
- On a tick in RUN:
  - If the output slot is free (o_valid == 0, or o_valid & i_ready in the same cycle): o_data <= i_lut_data at the current o_lut_addr, o_valid <= 1, and phase <= phase + step (modulo 2**(ADDR_W+FRAC_W)).
  - Otherwise the tick is dropped, phase holds, and o_overrun <= 1.
- Latency: the sample appears on o_data/o_valid one clock after the tick. The ROM address is stable for the whole tick cycle.
- Wrap:
  - The carry out of the phase add pulses o_beat in the same cycle the new sample is registered.
  - In one-shot mode the wrap moves RUN to FLUSH.
  - FLUSH -> IDLE once o_valid & i_ready; no further ticks are taken in FLUSH.
- step = 0: the same address is emitted on every tick and no wrap ever occurs.
- Handshake: o_valid stays high and o_data stays stable until accepted. o_valid clears on acceptance when no new sample is loaded in the same cycle.
- o_busy = 1 in RUN and FLUSH.
- Config inputs are ignored except on i_start.
- An asynchronous reset mid-run returns to the reset values immediately.

Decomposition:
- Shared package wavegen_pkg:
  - ADDR_W/DATA_W/FRAC_W/DIV_W defaults.
  - State enum seq_state_t {IDLE, RUN, FLUSH}.
  - Phase typedef.
- One natural sub-module: wave_rate_div (divider counter with load/clear, tick output).
- The ROM itself stays external and is connected through o_lut_addr/i_lut_data.

Test Plan:
- Reset, then start with step = 64 (1 address/sample), div = 0, loop, i_ready = 1 -> o_lut_addr runs 0,1,2..., o_data matches ROM[n] one cycle later, o_beat pulses after address 1023, and the stream resumes at 0.
- step = 32 (half rate), div = 3 -> each address is emitted twice, one sample every 4 clocks, 2048 samples per beat.
- One-shot, step = 1024 (16 addresses/sample), div = 0 -> 64 samples (addresses 0,16,...,1008), o_beat on the 64th, FLUSH held while i_ready = 0, IDLE after acceptance, o_busy falls.
- Hold i_ready = 0 for 10 clocks with div = 0 -> o_data stays frozen, phase holds, o_overrun = 1; a later i_start clears it.
- i_stop and i_start asserted together mid-run -> IDLE, o_valid = 0, phase = 0.
- Assert i_rst at sample 500 -> all outputs reach reset values without waiting for a clock edge. After release and i_start, the stream restarts at address 0.
